// File: rtl/uart_rx.sv
// UART receive engine: 8N1 (or 8E1 with UART_RX_PARITY_EN) deserialiser using
// 4x oversampling with 3-sample majority vote; result pulses are one cycle wide.
`timescale 1ns/1ps

module uart_rx #(
    parameter int unsigned CLOCK_DIVIDE = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       received,
    output logic       recv_error,
    output logic       break_det,
    output logic       parity_error,
    output logic       is_receiving
);

    localparam int unsigned DIV_W = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLOCK_DIVIDE - 1);

    localparam logic [2:0] ST_HUNT   = 3'd0;
    localparam logic [2:0] ST_IDLE   = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY = 3'd4;
`endif
    localparam logic [2:0] ST_STOP   = 3'd5;

    logic             sync1;
    logic             rxs;

    logic [2:0]       state,        state_d;
    logic [DIV_W-1:0] div_cnt,      div_cnt_d;
    logic [1:0]       phase,        phase_d;
    logic             s0,           s0_d;
    logic             s1,           s1_d;
    logic [3:0]       bit_cnt,      bit_cnt_d;
    logic [7:0]       shift,        shift_d;
    logic             par_ok,       par_ok_d;
    logic [1:0]       hunt_cnt,     hunt_cnt_d;
    logic [7:0]       rx_byte_d;
    logic             received_d;
    logic             recv_error_d;
    logic             break_det_d;
    logic             parity_error_d;
    logic             is_receiving_d;

    logic             tick_c;
    logic             maj_c;
    logic             decide_c;
    logic             phase_end_c;

    // Two-flop synchroniser; idle-high reset keeps a fresh reset from seeing a start bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b1;
            rxs   <= 1'b1;
        end else begin
            sync1 <= rx;
            rxs   <= sync1;
        end
    end

    assign tick_c      = (div_cnt == DIV_LAST);
    assign maj_c       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
    assign decide_c    = tick_c && (phase == 2'd2);
    assign phase_end_c = tick_c && (phase == 2'd3);

    // Next-state, datapath and output decode.
    always_comb begin
        state_d        = state;
        div_cnt_d      = tick_c ? '0 : div_cnt + DIV_W'(1);
        phase_d        = tick_c ? phase + 2'd1 : phase;
        s0_d           = s0;
        s1_d           = s1;
        bit_cnt_d      = bit_cnt;
        shift_d        = shift;
        par_ok_d       = par_ok;
        hunt_cnt_d     = hunt_cnt;
        rx_byte_d      = rx_byte;
        received_d     = 1'b0;
        recv_error_d   = 1'b0;
        break_det_d    = 1'b0;
        parity_error_d = 1'b0;

        if (tick_c && (phase == 2'd0)) s0_d = rxs;
        if (tick_c && (phase == 2'd1)) s1_d = rxs;

        case (state)
            ST_HUNT: begin
                if (!rxs) begin
                    hunt_cnt_d = 2'd0;
                end else if (tick_c) begin
                    if (hunt_cnt == 2'd3) begin
                        hunt_cnt_d = 2'd0;
                        state_d    = ST_IDLE;
                    end else begin
                        hunt_cnt_d = hunt_cnt + 2'd1;
                    end
                end
            end
            ST_IDLE: begin
                if (!rxs) begin
                    div_cnt_d = '0;
                    phase_d   = 2'd0;
                    bit_cnt_d = 4'd0;
                    par_ok_d  = 1'b1;
                    state_d   = ST_START;
                end
            end
            ST_START: begin
                if (decide_c) state_d = maj_c ? ST_IDLE : ST_DATA;
            end
            ST_DATA: begin
                // The start bit's phase-3 tick also lands here; bit_cnt is still 0 then.
                if (decide_c) begin
                    shift_d   = {maj_c, shift[7:1]};
                    bit_cnt_d = bit_cnt + 4'd1;
                end
                if (phase_end_c && (bit_cnt == 4'd8)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = ST_PARITY;
`else
                    state_d = ST_STOP;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (decide_c)    par_ok_d = ~(^{maj_c, shift});
                if (phase_end_c) state_d  = ST_STOP;
            end
`endif
            ST_STOP: begin
                // Frame ends at the phase-2 decision so a back-to-back start bit is not missed.
                if (decide_c) begin
                    if (maj_c) begin
                        if (par_ok) begin
                            rx_byte_d  = shift;
                            received_d = 1'b1;
                        end else begin
                            recv_error_d = 1'b1;
`ifdef UART_RX_PARITY_EN
                            parity_error_d = 1'b1;
`endif
                        end
                        state_d = ST_IDLE;
                    end else begin
                        recv_error_d = 1'b1;
                        break_det_d  = (shift == 8'h00);
                        hunt_cnt_d   = 2'd0;
                        state_d      = ST_HUNT;
                    end
                end
            end
            default: begin
                state_d = ST_HUNT;
            end
        endcase

        is_receiving_d = (state_d != ST_HUNT) && (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_HUNT;
            div_cnt      <= '0;
            phase        <= 2'd0;
            s0           <= 1'b1;
            s1           <= 1'b1;
            bit_cnt      <= 4'd0;
            shift        <= 8'h00;
            par_ok       <= 1'b1;
            hunt_cnt     <= 2'd0;
            rx_byte      <= 8'h00;
            received     <= 1'b0;
            recv_error   <= 1'b0;
            break_det    <= 1'b0;
            parity_error <= 1'b0;
            is_receiving <= 1'b0;
        end else begin
            state        <= state_d;
            div_cnt      <= div_cnt_d;
            phase        <= phase_d;
            s0           <= s0_d;
            s1           <= s1_d;
            bit_cnt      <= bit_cnt_d;
            shift        <= shift_d;
            par_ok       <= par_ok_d;
            hunt_cnt     <= hunt_cnt_d;
            rx_byte      <= rx_byte_d;
            received     <= received_d;
            recv_error   <= recv_error_d;
            break_det    <= break_det_d;
            parity_error <= parity_error_d;
            is_receiving <= is_receiving_d;
        end
    end

endmodule
